// File: rtl/fifo_array_sync.sv
// fifo_array_sync
//   Single-clock bank of ARRAY_SIZE independent FIFOs. It buffers systolic-array
//   output columns before write-back. Each channel has its own pointers,
//   occupancy level and sticky overflow/underflow flags. There are two drain modes:
//     - independent (lockstep=0): every channel pops on its own r_en bit.
//     - lockstep    (lockstep=1): rd_ready pops every channel in the same cycle,
//       but only when all channels hold data, so the output rows stay aligned.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   clear             synchronous flush; takes priority over every other input
//   lockstep          drain mode select
//   w_en, in_bus      per-channel write request and packed write data
//   r_en              per-channel read request (independent mode)
//   rd_ready          row read request (lockstep mode)
//   out_bus           registered read data, one DATA_SIZE slice per channel
//   out_valid         1-cycle pulse per pop, one bit per channel
//   row_avail         every channel is non-empty
//   empty, full       per-channel occupancy decodes
//   level             per-channel occupancy 0..DEPTH, packed (LOG_DEPTH+1) bits each
//   overflow          sticky: a write was attempted while the channel was full
//   underflow         sticky: an independent read was attempted while the channel was empty
module fifo_array_sync #(
    parameter int DATA_SIZE  = 16,
    parameter int DEPTH      = 64,
    parameter int LOG_DEPTH  = 6,
    parameter int ARRAY_SIZE = 9
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic                              lockstep,
    input  logic [ARRAY_SIZE-1:0]             w_en,
    input  logic [DATA_SIZE*ARRAY_SIZE-1:0]   in_bus,
    input  logic [ARRAY_SIZE-1:0]             r_en,
    input  logic                              rd_ready,
    output logic [DATA_SIZE*ARRAY_SIZE-1:0]   out_bus,
    output logic [ARRAY_SIZE-1:0]             out_valid,
    output logic                              row_avail,
    output logic [ARRAY_SIZE-1:0]             empty,
    output logic [ARRAY_SIZE-1:0]             full,
    output logic [(LOG_DEPTH+1)*ARRAY_SIZE-1:0] level,
    output logic [ARRAY_SIZE-1:0]             overflow,
    output logic [ARRAY_SIZE-1:0]             underflow
);

    localparam int LW = LOG_DEPTH + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic pop_row;

    assign row_avail = &(~empty);
    assign pop_row   = lockstep & rd_ready & row_avail;

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_ch
        logic [DATA_SIZE-1:0] mem [DEPTH];
        logic [LOG_DEPTH-1:0] wptr;
        logic [LOG_DEPTH-1:0] rptr;
        logic [LW-1:0]        lvl;
        logic [DATA_SIZE-1:0] dout;
        logic                 vld;
        logic                 ovf;
        logic                 udf;
        logic                 wr;
        logic                 rd;

        assign empty[i] = (lvl == '0);
        assign full[i]  = (lvl == FULL_LVL);

        // A write into a full channel is dropped even if the same cycle pops,
        // and a pop from an empty channel is refused (no fall-through).
        assign wr = w_en[i] & ~full[i] & ~clear;
        assign rd = ~clear & (lockstep ? pop_row : (r_en[i] & ~empty[i]));

        // Storage is deliberately left out of reset.
        always_ff @(posedge clk) begin
            if (wr) begin
                mem[wptr] <= in_bus[i*DATA_SIZE +: DATA_SIZE];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr <= '0;
                rptr <= '0;
                lvl  <= '0;
                dout <= '0;
                vld  <= 1'b0;
                ovf  <= 1'b0;
                udf  <= 1'b0;
            end else if (clear) begin
                // out_bus keeps its last value through a flush.
                wptr <= '0;
                rptr <= '0;
                lvl  <= '0;
                vld  <= 1'b0;
                ovf  <= 1'b0;
                udf  <= 1'b0;
            end else begin
                if (wr) begin
                    wptr <= wptr + 1'b1;
                end
                if (rd) begin
                    rptr <= rptr + 1'b1;
                    dout <= mem[rptr];
                end
                vld <= rd;
                if (wr && !rd) begin
                    lvl <= lvl + 1'b1;
                end else if (!wr && rd) begin
                    lvl <= lvl - 1'b1;
                end
                if (w_en[i] && full[i]) begin
                    ovf <= 1'b1;
                end
                if (!lockstep && r_en[i] && empty[i]) begin
                    udf <= 1'b1;
                end
            end
        end

        assign out_bus[i*DATA_SIZE +: DATA_SIZE] = dout;
        assign out_valid[i]                     = vld;
        assign level[i*LW +: LW]                = lvl;
        assign overflow[i]                      = ovf;
        assign underflow[i]                     = udf;
    end

endmodule

// File: tb/tb_fifo_array_sync.sv
module tb_fifo_array_sync;

    localparam int DW = 16;
    localparam int D  = 64;
    localparam int LD = 6;
    localparam int N  = 9;
    localparam int LW = LD + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              lockstep = 1'b0;
    logic              rd_ready = 1'b0;
    logic [N-1:0]      w_en = '0;
    logic [N-1:0]      r_en = '0;
    logic [DW*N-1:0]   in_bus = '0;
    logic [DW*N-1:0]   out_bus;
    logic [N-1:0]      out_valid;
    logic              row_avail;
    logic [N-1:0]      empty;
    logic [N-1:0]      full;
    logic [LW*N-1:0]   level;
    logic [N-1:0]      overflow;
    logic [N-1:0]      underflow;

    fifo_array_sync #(
        .DATA_SIZE(DW), .DEPTH(D), .LOG_DEPTH(LD), .ARRAY_SIZE(N)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .lockstep(lockstep),
        .w_en(w_en), .in_bus(in_bus), .r_en(r_en), .rd_ready(rd_ready),
        .out_bus(out_bus), .out_valid(out_valid), .row_avail(row_avail),
        .empty(empty), .full(full), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one queue per channel plus expected registered outputs.
    logic [DW-1:0]   mq [N][$];
    logic [DW*N-1:0] e_out;
    logic [N-1:0]    e_valid;
    logic [N-1:0]    e_ov;
    logic [N-1:0]    e_uf;

    function automatic logic [N-1:0] m_empty();
        logic [N-1:0] r;
        for (int c = 0; c < N; c++) r[c] = (mq[c].size() == 0);
        return r;
    endfunction

    function automatic logic [N-1:0] m_full();
        logic [N-1:0] r;
        for (int c = 0; c < N; c++) r[c] = (mq[c].size() == D);
        return r;
    endfunction

    function automatic logic [LW*N-1:0] m_level();
        logic [LW*N-1:0] r;
        for (int c = 0; c < N; c++) r[c*LW +: LW] = LW'(mq[c].size());
        return r;
    endfunction

    function automatic logic [DW*N-1:0] rand_bus();
        logic [DW*N-1:0] r;
        for (int c = 0; c < N; c++) r[c*DW +: DW] = DW'($urandom());
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) mq[c].delete();
        e_out = '0;
        e_valid = '0;
        e_ov = '0;
        e_uf = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] emp;
        logic [N-1:0] ful;
        logic         row;
        emp = m_empty();
        ful = m_full();
        row = (emp == '0);
        if (clear) begin
            for (int c = 0; c < N; c++) mq[c].delete();
            e_valid = '0;
            e_ov = '0;
            e_uf = '0;
            return;
        end
        for (int c = 0; c < N; c++) begin
            logic pop;
            pop = lockstep ? (rd_ready && row) : (r_en[c] && !emp[c]);
            if (!lockstep && r_en[c] && emp[c]) e_uf[c] = 1'b1;
            if (w_en[c] && ful[c]) e_ov[c] = 1'b1;
            e_valid[c] = pop;
            if (pop) e_out[c*DW +: DW] = mq[c].pop_front();
            if (w_en[c] && !ful[c]) mq[c].push_back(in_bus[c*DW +: DW]);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 1'b0;
        w_en = '0;
        r_en = '0;
        rd_ready = 1'b0;
        in_bus = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (empty !== 9'h1FF) begin miscompares++; $display("FAIL reset_empty: got %h expected %h", empty, 9'h1FF); end
        vectors++; if (level !== '0) begin miscompares++; $display("FAIL reset_level: got %h expected 0", level); end
        vectors++; if (row_avail !== 1'b0) begin miscompares++; $display("FAIL reset_row_avail: got %b expected 0", row_avail); end
        @(negedge clk);
        rst_n = 1'b1;
        // traffic, including reads of empty channels so flags are set
        r_en = 9'h1FF;
        cycle();
        for (int k = 0; k < 10; k++) begin
            w_en = N'($urandom());
            r_en = N'($urandom());
            in_bus = rand_bus();
            cycle();
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++; if (empty !== 9'h1FF) begin miscompares++; $display("FAIL midreset_empty: got %h expected %h", empty, 9'h1FF); end
        vectors++; if (level !== '0) begin miscompares++; $display("FAIL midreset_level: got %h expected 0", level); end
        vectors++; if (out_valid !== '0) begin miscompares++; $display("FAIL midreset_valid: got %h expected 0", out_valid); end
        vectors++; if (out_bus !== '0) begin miscompares++; $display("FAIL midreset_out_bus: got %h expected 0", out_bus); end
        vectors++; if ({overflow, underflow} !== '0) begin miscompares++; $display("FAIL midreset_flags: got %h/%h expected 0/0", overflow, underflow); end
        vectors++; if (full !== '0) begin miscompares++; $display("FAIL midreset_full: got %h expected 0", full); end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill_overflow();
        idle();
        for (int k = 0; k <= 64; k++) begin
            w_en = 9'h001;
            in_bus = '0;
            in_bus[DW-1:0] = DW'(k);
            cycle();
            if (k == 63) begin
                vectors++; if (full[0] !== 1'b1 || level[LW-1:0] !== 7'd64) begin miscompares++; $display("FAIL fill_full: got full=%b level=%0d expected 1/64", full[0], level[LW-1:0]); end
                vectors++; if (overflow[0] !== 1'b0) begin miscompares++; $display("FAIL fill_no_overflow_yet: got %b expected 0", overflow[0]); end
            end
        end
        vectors++; if (overflow[0] !== 1'b1 || level[LW-1:0] !== 7'd64) begin miscompares++; $display("FAIL fill_overflow: got ovf=%b level=%0d expected 1/64", overflow[0], level[LW-1:0]); end
        idle();
        r_en = 9'h001;
        for (int k = 0; k < 64; k++) begin
            cycle();
            vectors++; if (out_valid[0] !== 1'b1 || out_bus[DW-1:0] !== DW'(k)) begin miscompares++; $display("FAIL drain_data[%0d]: got v=%b d=%h expected 1/%h", k, out_valid[0], out_bus[DW-1:0], DW'(k)); end
        end
        idle();
        vectors++; if (empty[0] !== 1'b1 || underflow[0] !== 1'b0) begin miscompares++; $display("FAIL drain_end: got empty=%b udf=%b expected 1/0", empty[0], underflow[0]); end
    endtask

    task automatic test_wrap();
        for (int p = 0; p < 2; p++) begin
            idle();
            w_en = 9'h001;
            for (int k = 0; k < 48; k++) begin
                in_bus = rand_bus();
                cycle();
            end
            idle();
            r_en = 9'h001;
            for (int k = 0; k < 48; k++) begin
                cycle();
                vectors++; if (out_valid[0] !== 1'b1 || out_bus[DW-1:0] !== e_out[DW-1:0]) begin miscompares++; $display("FAIL wrap_data[%0d,%0d]: got v=%b d=%h expected 1/%h", p, k, out_valid[0], out_bus[DW-1:0], e_out[DW-1:0]); end
            end
        end
        idle();
        vectors++; if (empty[0] !== 1'b1) begin miscompares++; $display("FAIL wrap_empty: got %b expected 1", empty[0]); end
    endtask

    task automatic test_lockstep();
        idle();
        clear = 1'b1;
        cycle();
        idle();
        w_en = 9'h0FF;
        in_bus = rand_bus();
        cycle();
        idle();
        lockstep = 1'b1;
        rd_ready = 1'b1;
        r_en = 9'h1FF;
        cycle();
        vectors++; if (out_valid !== '0 || row_avail !== 1'b0) begin miscompares++; $display("FAIL lock_no_pop: got v=%h row=%b expected 0/0", out_valid, row_avail); end
        vectors++; if (level !== m_level() || underflow !== '0) begin miscompares++; $display("FAIL lock_hold: got level=%h udf=%h expected %h/0", level, underflow, m_level()); end
        idle();
        w_en = 9'h100;
        in_bus = rand_bus();
        cycle();
        vectors++; if (row_avail !== 1'b1) begin miscompares++; $display("FAIL lock_row_avail: got %b expected 1", row_avail); end
        idle();
        rd_ready = 1'b1;
        cycle();
        vectors++; if (out_valid !== 9'h1FF || out_bus !== e_out) begin miscompares++; $display("FAIL lock_pop: got v=%h d=%h expected 1ff/%h", out_valid, out_bus, e_out); end
        vectors++; if (empty !== 9'h1FF) begin miscompares++; $display("FAIL lock_empty: got %h expected 1ff", empty); end
        idle();
        lockstep = 1'b0;
    endtask

    task automatic test_simultaneous();
        idle();
        clear = 1'b1;
        cycle();
        idle();
        w_en = 9'h008;
        for (int k = 0; k < 5; k++) begin
            in_bus = rand_bus();
            cycle();
        end
        vectors++; if (level[3*LW +: LW] !== 7'd5) begin miscompares++; $display("FAIL simul_level5: got %0d expected 5", level[3*LW +: LW]); end
        r_en = 9'h008;
        in_bus = rand_bus();
        cycle();
        vectors++; if (level[3*LW +: LW] !== 7'd5 || out_valid[3] !== 1'b1 || out_bus[3*DW +: DW] !== e_out[3*DW +: DW]) begin miscompares++; $display("FAIL simul_rw: got level=%0d v=%b d=%h expected 5/1/%h", level[3*LW +: LW], out_valid[3], out_bus[3*DW +: DW], e_out[3*DW +: DW]); end
        idle();
        r_en = 9'h008;
        repeat (5) cycle();
        vectors++; if (empty[3] !== 1'b1 || underflow[3] !== 1'b0) begin miscompares++; $display("FAIL simul_drained: got empty=%b udf=%b expected 1/0", empty[3], underflow[3]); end
        w_en = 9'h008;
        in_bus = rand_bus();
        cycle();
        vectors++; if (level[3*LW +: LW] !== 7'd1 || underflow[3] !== 1'b1 || out_valid[3] !== 1'b0) begin miscompares++; $display("FAIL simul_empty_rw: got level=%0d udf=%b v=%b expected 1/1/0", level[3*LW +: LW], underflow[3], out_valid[3]); end
        idle();
    endtask

    task automatic test_clear();
        idle();
        w_en = 9'h1FF;
        for (int k = 0; k < 3; k++) begin
            in_bus = rand_bus();
            cycle();
        end
        r_en = 9'h1FF;
        in_bus = rand_bus();
        cycle();
        clear = 1'b1;
        in_bus = rand_bus();
        cycle();
        vectors++; if (level !== '0 || out_valid !== '0) begin miscompares++; $display("FAIL clear_state: got level=%h v=%h expected 0/0", level, out_valid); end
        vectors++; if (overflow !== '0 || underflow !== '0) begin miscompares++; $display("FAIL clear_flags: got %h/%h expected 0/0", overflow, underflow); end
        vectors++; if (out_bus !== e_out) begin miscompares++; $display("FAIL clear_out_hold: got %h expected %h", out_bus, e_out); end
        idle();
        r_en = 9'h1FF;
        cycle();
        vectors++; if (out_valid !== '0 || underflow !== 9'h1FF) begin miscompares++; $display("FAIL clear_nothing_stored: got v=%h udf=%h expected 0/1ff", out_valid, underflow); end
        idle();
    endtask

    task automatic test_random();
        int wp;
        int rp;
        wp = 50;
        rp = 50;
        idle();
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) begin
                wp = $urandom_range(10, 95);
                rp = $urandom_range(10, 95);
            end
            for (int c = 0; c < N; c++) begin
                w_en[c] = ($urandom_range(0, 99) < wp);
                r_en[c] = ($urandom_range(0, 99) < rp);
            end
            in_bus = rand_bus();
            rd_ready = ($urandom_range(0, 99) < rp);
            if ($urandom_range(0, 99) < 3) lockstep = ~lockstep;
            clear = ($urandom_range(0, 999) < 4);
            cycle();
            vectors++; if (out_valid !== e_valid) begin miscompares++; $display("FAIL rand_valid @%0d: got %h expected %h", k, out_valid, e_valid); end
            vectors++; if (out_bus !== e_out) begin miscompares++; $display("FAIL rand_data @%0d: got %h expected %h", k, out_bus, e_out); end
            vectors++; if (level !== m_level()) begin miscompares++; $display("FAIL rand_level @%0d: got %h expected %h", k, level, m_level()); end
            vectors++; if (empty !== m_empty() || full !== m_full()) begin miscompares++; $display("FAIL rand_empty_full @%0d: got %h/%h expected %h/%h", k, empty, full, m_empty(), m_full()); end
            vectors++; if (row_avail !== (m_empty() == '0)) begin miscompares++; $display("FAIL rand_row_avail @%0d: got %b expected %b", k, row_avail, (m_empty() == '0)); end
            vectors++; if (overflow !== e_ov || underflow !== e_uf) begin miscompares++; $display("FAIL rand_flags @%0d: got %h/%h expected %h/%h", k, overflow, underflow, e_ov, e_uf); end
        end
        idle();
        lockstep = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_wrap();
        test_lockstep();
        test_simultaneous();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
